// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage MUL/DIV issue sequencer in front of the multdiv unit.
// Define MULTDIV_TIMEOUT_EN to build the BUSY watchdog.
module multdiv_issue_ctrl #(
  parameter int EXC_REG        = 30,
  parameter int MULT_EXC_CODE  = 4,
  parameter int DIV_EXC_CODE   = 5,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int TIMEOUT_CODE   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_mult,
  input  logic        op_is_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  dest_reg,
  input  logic        flush,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  logic        is_mult_q;
  logic [4:0]  rd_q;
  logic        wb_valid_q;
  logic        accept;
  logic        expired;

  assign accept = op_valid & (op_is_mult | op_is_div);

  assign stall = ((state == IDLE) & accept)
               | (state == START)
               | (state == BUSY);

  // A flush in DONE squashes the writeback in the same cycle.
  assign wb_valid = wb_valid_q & ~flush;

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ctrl_MULT    <= 1'b0;
      ctrl_DIV     <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_exception <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      md_operand_a <= '0;
      md_operand_b <= '0;
      is_mult_q    <= 1'b0;
      rd_q         <= '0;
    end else begin
      ctrl_MULT  <= 1'b0;
      ctrl_DIV   <= 1'b0;
      wb_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !flush) begin
            md_operand_a <= operand_a;
            md_operand_b <= operand_b;
            rd_q         <= dest_reg;
            is_mult_q    <= op_is_mult;
            ctrl_MULT    <= op_is_mult;
            ctrl_DIV     <= ~op_is_mult;
            state        <= START;
          end
        end
        // RDY here may be left over from the previous op.
        START: begin
          state <= flush ? IDLE : BUSY;
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else if (md_resultRDY) begin
            state      <= DONE;
            wb_valid_q <= 1'b1;
            if (md_exception) begin
              wb_reg       <= 5'(EXC_REG);
              wb_data      <= is_mult_q ? 32'(MULT_EXC_CODE)
                                        : 32'(DIV_EXC_CODE);
              wb_exception <= 1'b1;
            end else begin
              wb_reg       <= rd_q;
              wb_data      <= md_result;
              wb_exception <= 1'b0;
            end
          end else if (expired) begin
            state        <= DONE;
            wb_valid_q   <= 1'b1;
            wb_reg       <= 5'(EXC_REG);
            wb_data      <= 32'(TIMEOUT_CODE);
            wb_exception <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
